jt49_tone_gen: RTL and testbench

Consumer end of the JT49 clock-enable path: takes the divided enable pulse stream (`cen`, one `clk` cycle wide) and turns it into the three square-wave tone channels and the pseudo-random noise bit that feed the mixer. Each channel is a 12-bit period counter advanced only on `cen`. The noise source is a 5-bit period counter driving a 17-bit LFSR.

---
 rtl/jt49_pkg.sv | 18 +
 rtl/jt49_tone_div.sv | 52 +++++
 rtl/jt49_tone_gen.sv | 98 +++++++++
 tb/tb_jt49_tone_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared constants for the JT49 tone/noise generator: counter widths,
// LFSR geometry and the default LFSR seed.
package jt49_pkg;

    localparam int unsigned TONE_W    = 12;
    localparam int unsigned NOISE_W   = 5;
    localparam int unsigned LFSR_W    = 17;
    localparam int unsigned LFSR_TAP0 = 0;
    localparam int unsigned LFSR_TAP1 = 3;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 17'h1;

    // One right shift of the noise LFSR; the feedback enters at the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
        return {state[LFSR_TAP0] ^ state[LFSR_TAP1], state[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/jt49_tone_div.sv
// Enable-gated half-period counter with a toggling output and a one-cycle
// toggle pulse. A period of 0 behaves as 1. The compare is >= so a period
// decrease below the current count wraps on the next enable.
// wrap is the combinational wrap condition, for consumers that must act on
// the same edge as the toggle.
module jt49_tone_div
    import jt49_pkg::*;
#(
    parameter int unsigned W = TONE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] period,
    output logic         tone,
    output logic         pulse,
    output logic         wrap
);

    logic [W-1:0] cnt;
    logic [W-1:0] limit;
    logic         at_limit;

    // Terminal count is max(period,1)-1
    always_comb begin
        limit    = (period == '0) ? '0 : period - W'(1);
        at_limit = (cnt >= limit);
    end

    assign wrap = cen && at_limit;

    // Count on enable; wrap toggles the output and raises the pulse for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            tone  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (cen) begin
                if (at_limit) begin
                    cnt   <= '0;
                    tone  <= ~tone;
                    pulse <= 1'b1;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/jt49_tone_gen.sv
// JT49 tone generator: three square-wave channels and a pseudo-random
// noise bit, all advanced by the cen enable pulse.
// Build option: JT49_NOISE_EN builds the noise prescaler, counter and LFSR;
// without it noise is constant 1 and noise_period is ignored.
module jt49_tone_gen
    import jt49_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic [TONE_W-1:0]  period_a,
    input  logic [TONE_W-1:0]  period_b,
    input  logic [TONE_W-1:0]  period_c,
    input  logic [NOISE_W-1:0] noise_period,
    output logic               tone_a,
    output logic               tone_b,
    output logic               tone_c,
    output logic [2:0]         tone_edge,
    output logic               noise
);

    // Tone channels only need the registered pulse, not the early wrap
    logic [2:0] tone_wrap_unused;

    jt49_tone_div #(.W(TONE_W)) u_div_a (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .period (period_a),
        .tone   (tone_a),
        .pulse  (tone_edge[0]),
        .wrap   (tone_wrap_unused[0])
    );

    jt49_tone_div #(.W(TONE_W)) u_div_b (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .period (period_b),
        .tone   (tone_b),
        .pulse  (tone_edge[1]),
        .wrap   (tone_wrap_unused[1])
    );

    jt49_tone_div #(.W(TONE_W)) u_div_c (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .period (period_c),
        .tone   (tone_c),
        .pulse  (tone_edge[2]),
        .wrap   (tone_wrap_unused[2])
    );

`ifdef JT49_NOISE_EN
    logic              pre;
    logic              noise_wrap;
    logic              noise_tone_unused;
    logic              noise_pulse_unused;
    logic [LFSR_W-1:0] lfsr;

    // Prescaler: the noise counter sees every second cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      pre <= 1'b0;
        else if (cen) pre <= ~pre;
    end

    // The LFSR shifts on the combinational wrap so it moves on the same
    // edge the counter wraps, not one cycle after the registered pulse.
    jt49_tone_div #(.W(NOISE_W)) u_div_noise (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen & pre),
        .period (noise_period),
        .tone   (noise_tone_unused),
        .pulse  (noise_pulse_unused),
        .wrap   (noise_wrap)
    );

    // LFSR advances once per noise counter wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             lfsr <= SEED;
        else if (noise_wrap) lfsr <= lfsr_next(lfsr);
    end

    assign noise = lfsr[0];
`else
    logic [NOISE_W-1:0] noise_period_unused;
    logic [LFSR_W-1:0]  seed_unused;

    assign noise_period_unused = noise_period;
    assign seed_unused         = SEED;
    assign noise               = 1'b1;
`endif

endmodule

// File: tb/tb_jt49_tone_gen.sv
// Directed bench for jt49_tone_gen: divide, zero period, period decrease,
// enable hold, asynchronous reset and noise sequence.
module tb_jt49_tone_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic [11:0] period_a;
    logic [11:0] period_b;
    logic [11:0] period_c;
    logic [4:0]  noise_period;
    logic        tone_a;
    logic        tone_b;
    logic        tone_c;
    logic [2:0]  tone_edge;
    logic        noise;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference noise state, stepped alongside cen
    logic [16:0] ref_lfsr;
    logic        ref_pre;

    always #5 clk = ~clk;

    jt49_tone_gen #(.SEED(17'h1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .period_a     (period_a),
        .period_b     (period_b),
        .period_c     (period_c),
        .noise_period (noise_period),
        .tone_a       (tone_a),
        .tone_b       (tone_b),
        .tone_c       (tone_c),
        .tone_edge    (tone_edge),
        .noise        (noise)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    // One clock with the given cen, driven and sampled on the falling edge
    task automatic step(input logic c);
        cen = c;
        @(posedge clk);
        if (c) begin
            if (ref_pre) ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[3], ref_lfsr[16:1]};
            ref_pre = ~ref_pre;
        end
        @(negedge clk);
        cen = 1'b0;
    endtask

    function automatic logic exp_noise();
`ifdef JT49_NOISE_EN
        return ref_lfsr[0];
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        logic [8:0] tbl_a;
        logic [8:0] tbl_e;
        logic [3:0] tbl_b;

        rst          = 1'b1;
        cen          = 1'b0;
        period_a     = 12'd3;
        period_b     = 12'd100;
        period_c     = 12'd100;
        noise_period = 5'd1;
        ref_lfsr     = 17'h1;
        ref_pre      = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_tone_a", tone_a, 0);
        check("reset_tone_b", tone_b, 0);
        check("reset_tone_c", tone_c, 0);
        check("reset_edge", tone_edge, 3'b000);
        check("reset_noise", noise, 1);
        rst = 1'b0;

        // Basic divide: period 3, cen every 4 clocks
        tbl_a = 9'b100011100;
        tbl_e = 9'b100100100;
        for (int k = 0; k < 9; k++) begin
            step(1'b1);
            check("basic_tone_a", tone_a, tbl_a[k]);
            check("basic_edge", tone_edge, {2'b00, tbl_e[k]});
            step(1'b0);
            check("basic_edge_clear", tone_edge, 3'b000);
            step(1'b0);
            step(1'b0);
        end

        // Mid-count decrease on channel C: count 9 -> 50, then period 10
        period_a = 12'hFFF;
        repeat (41) step(1'b1);
        check("dec_before", tone_c, 0);
        period_c = 12'd10;
        step(1'b1);
        check("dec_wrap_tone", tone_c, 1);
        check("dec_wrap_edge", tone_edge, 3'b100);
        repeat (9) step(1'b1);
        check("dec_hold", tone_c, 1);
        step(1'b1);
        check("dec_half_tone", tone_c, 0);
        check("dec_half_edge", tone_edge, 3'b100);

        // Zero period vs period 1 on channel B, cen every cycle
        tbl_b = 4'b0101;
        period_b = 12'd0;
        for (int j = 0; j < 4; j++) begin
            step(1'b1);
            check("zero_tone_b", tone_b, tbl_b[j]);
            check("zero_edge", tone_edge, 3'b010);
        end
        period_b = 12'd1;
        for (int j = 0; j < 4; j++) begin
            step(1'b1);
            check("one_tone_b", tone_b, tbl_b[j]);
            check("one_edge", tone_edge, 3'b010);
        end

        // No-cen hold for 1000 clocks; C resumes at count 8 of limit 9
        repeat (1000) step(1'b0);
        check("hold_tone_a", tone_a, 1);
        check("hold_tone_b", tone_b, 0);
        check("hold_tone_c", tone_c, 0);
        check("hold_edge", tone_edge, 3'b000);
        step(1'b1);
        check("resume1_tone_b", tone_b, 1);
        check("resume1_tone_c", tone_c, 0);
        check("resume1_edge", tone_edge, 3'b010);
        step(1'b1);
        check("resume2_tone_c", tone_c, 1);
        check("resume2_edge", tone_edge, 3'b110);

        // Asynchronous reset between clock edges
        check("pre_rst_tone_a", tone_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_tone_a", tone_a, 0);
        check("async_tone_c", tone_c, 0);
        check("async_noise", noise, 1);
        ref_lfsr = 17'h1;
        ref_pre  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        period_a = 12'd3;

        step(1'b1);
        check("post_rst1_tone_a", tone_a, 0);
        check("post_rst1_edge", tone_edge, 3'b010);
        check("post_rst1_noise", noise, exp_noise());
        step(1'b1);
        check("post_rst2_tone_a", tone_a, 0);
        check("post_rst2_noise", noise, exp_noise());
        step(1'b1);
        check("post_rst3_tone_a", tone_a, 1);
        check("post_rst3_edge", tone_edge, 3'b011);
        check("post_rst3_noise", noise, exp_noise());

        // Noise sequence, noise_period 1: one LFSR shift every 2 cen
        for (int i = 0; i < 37; i++) begin
            step(1'b1);
            check("noise_seq", noise, exp_noise());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
